// File: rtl/shape_vote_filter.sv
// Windowed majority vote over per-inference class scores, with a margin check and a
// multi-window hysteresis commit that produces a stable shape code (1=O, 2=W, 3=I, 0=unknown).
module shape_vote_filter #(
  parameter int SCORE_WIDTH  = 32,
  parameter int CNT_WIDTH    = 32,
  parameter int VOTE_PERIOD  = 25000000,
  parameter int MIN_VOTES    = 4,
  parameter int MIN_MARGIN   = 2,
  parameter int HOLD_WINDOWS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          clear,
  input  logic                          valid_in,
  input  logic signed [SCORE_WIDTH-1:0] score0,
  input  logic signed [SCORE_WIDTH-1:0] score1,
  input  logic signed [SCORE_WIDTH-1:0] score2,
  output logic [2:0]                    shape_code,
  output logic                          window_done,
  output logic [2:0]                    cand_code,
  output logic [CNT_WIDTH-1:0]          win_votes
);

  // Timer is widened when CNT_WIDTH is too narrow to reach VOTE_PERIOD-1.
  localparam int TW = ($clog2(VOTE_PERIOD) > CNT_WIDTH) ? $clog2(VOTE_PERIOD) : CNT_WIDTH;
  localparam int SW = ($clog2(HOLD_WINDOWS + 1) < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [CNT_WIDTH+1:0] tot_t;
  typedef logic [TW-1:0]        tmr_t;
  typedef logic [SW-1:0]        streak_t;
  typedef enum logic {STABLE, PENDING} state_t;

  localparam tmr_t LAST = tmr_t'(VOTE_PERIOD - 1);

  tmr_t    timer;
  cnt_t    cnt    [3];
  cnt_t    cnt_nx [3];
  logic [1:0] vote_cls, win_cls;
  cnt_t    win_cnt, run_cnt;
  tot_t    total;
  logic [2:0] cand;
  logic    win_end;

  state_t  state, state_n;
  streak_t streak, streak_n, streak_inc;
  logic [2:0] pending, pending_n, shape_n;

  always_comb begin
    vote_cls = 2'd0;
    if (!(score0 >= score1 && score0 >= score2))
      vote_cls = (score1 >= score2) ? 2'd1 : 2'd2;
  end

  // Counts include the current-cycle vote so a window-end vote joins its own window.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_nx[i] = cnt[i];
      if (en && valid_in && vote_cls == 2'(i) && cnt[i] != '1)
        cnt_nx[i] = cnt[i] + cnt_t'(1);
    end
  end

  always_comb begin
    win_end = en && !clear && (timer == LAST);
    if (cnt_nx[0] >= cnt_nx[1] && cnt_nx[0] >= cnt_nx[2]) begin
      win_cls = 2'd0;
      win_cnt = cnt_nx[0];
      run_cnt = (cnt_nx[1] >= cnt_nx[2]) ? cnt_nx[1] : cnt_nx[2];
    end else if (cnt_nx[1] >= cnt_nx[2]) begin
      win_cls = 2'd1;
      win_cnt = cnt_nx[1];
      run_cnt = (cnt_nx[0] >= cnt_nx[2]) ? cnt_nx[0] : cnt_nx[2];
    end else begin
      win_cls = 2'd2;
      win_cnt = cnt_nx[2];
      run_cnt = (cnt_nx[0] >= cnt_nx[1]) ? cnt_nx[0] : cnt_nx[1];
    end
    total = tot_t'(cnt_nx[0]) + tot_t'(cnt_nx[1]) + tot_t'(cnt_nx[2]);
    cand  = '0;
    if (total >= tot_t'(MIN_VOTES) && (win_cnt - run_cnt) >= cnt_t'(MIN_MARGIN))
      cand = {1'b0, win_cls} + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer       <= '0;
      window_done <= 1'b0;
      cand_code   <= '0;
      win_votes   <= '0;
      for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      window_done <= win_end;
      if (en) begin
        if (clear || win_end) begin
          timer <= '0;
          for (int unsigned i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
          timer <= timer + tmr_t'(1);
          for (int unsigned i = 0; i < 3; i++) cnt[i] <= cnt_nx[i];
        end
      end
      if (win_end) begin
        cand_code <= cand;
        win_votes <= win_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STABLE;
      streak     <= '0;
      pending    <= '0;
      shape_code <= '0;
    end else begin
      state      <= state_n;
      streak     <= streak_n;
      pending    <= pending_n;
      shape_code <= shape_n;
    end
  end

  always_comb begin
    state_n    = state;
    streak_n   = streak;
    pending_n  = pending;
    shape_n    = shape_code;
    streak_inc = streak + streak_t'(1);
    if (en && clear) begin
      state_n  = STABLE;
      streak_n = '0;
    end else if (win_end) begin
      case (state)
        STABLE: begin
          if (cand == shape_code) begin
            streak_n = '0;
          end else if (HOLD_WINDOWS == 1) begin
            shape_n = cand;
          end else begin
            pending_n = cand;
            streak_n  = streak_t'(1);
            state_n   = PENDING;
          end
        end
        PENDING: begin
          if (cand == shape_code) begin
            state_n  = STABLE;
            streak_n = '0;
          end else if (cand == pending) begin
            if (streak_inc == streak_t'(HOLD_WINDOWS)) begin
              shape_n  = pending;
              state_n  = STABLE;
              streak_n = '0;
            end else begin
              streak_n = streak_inc;
            end
          end else begin
            pending_n = cand;
            streak_n  = streak_t'(1);
          end
        end
        default: state_n = STABLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_vote_filter.sv
// Directed bench for shape_vote_filter: window voting, ties, margin, hysteresis,
// en/clear priority, async reset and counter saturation (second narrow instance).
module tb_shape_vote_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clear, valid_in, clear2, valid2;
  logic signed [31:0] score0, score1, score2;
  logic [2:0]  shape_code, cand_code, shape_code2, cand_code2;
  logic        window_done, window_done2;
  logic [31:0] win_votes;
  logic [2:0]  win_votes2;
  logic [2:0]  pre_shape;
  int errors = 0;
  int checks = 0;

  shape_vote_filter #(.SCORE_WIDTH(32), .CNT_WIDTH(32), .VOTE_PERIOD(8),
                      .MIN_VOTES(2), .MIN_MARGIN(1), .HOLD_WINDOWS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .valid_in(valid_in),
    .score0(score0), .score1(score1), .score2(score2),
    .shape_code(shape_code), .window_done(window_done),
    .cand_code(cand_code), .win_votes(win_votes));

  shape_vote_filter #(.SCORE_WIDTH(32), .CNT_WIDTH(3), .VOTE_PERIOD(10),
                      .MIN_VOTES(2), .MIN_MARGIN(1), .HOLD_WINDOWS(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .clear(clear2), .valid_in(valid2),
    .score0(score0), .score1(score1), .score2(score2),
    .shape_code(shape_code2), .window_done(window_done2),
    .cand_code(cand_code2), .win_votes(win_votes2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-cycle window: na votes of scores a*, then nb votes of scores b*, starting at cycle 'first'.
  task automatic window(input int na, input int a0, input int a1, input int a2,
                        input int nb, input int b0, input int b1, input int b2,
                        input int first);
    int stray = 0;
    for (int i = 0; i < 8; i++) begin
      if (i >= first && i < first + na) begin
        valid_in = 1'b1; score0 = a0; score1 = a1; score2 = a2;
      end else if (i >= first + na && i < first + na + nb) begin
        valid_in = 1'b1; score0 = b0; score1 = b1; score2 = b2;
      end else begin
        valid_in = 1'b0;
      end
      if (i == 7) pre_shape = shape_code;
      tick();
      if (i < 7 && window_done) stray++;
    end
    valid_in = 1'b0;
    check("early_done", stray, 0);
    check("window_done", window_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_edges;
    int stray;
    rst = 1'b1; en = 1'b1; clear = 1'b0; valid_in = 1'b0; clear2 = 1'b0; valid2 = 1'b0;
    score0 = 0; score1 = 0; score2 = 0; pre_shape = '0;
    tick(); tick();
    check("rst_shape", shape_code, 0);
    check("rst_done", window_done, 0);
    check("rst_cand", cand_code, 0);
    check("rst_votes", win_votes, 0);
    rst = 1'b0;

    // Argmax ties
    window(3, 5, 5, 5, 0, 0, 0, 0, 0);
    check("tie_all_votes", win_votes, 3);
    check("tie_all_cand", cand_code, 1);
    window(3, -1, 7, 7, 0, 0, 0, 0, 0);
    check("tie_12_cand", cand_code, 2);
    window(3, -3, -9, -2, 0, 0, 0, 0, 0);
    check("neg_cand", cand_code, 3);
    check("neg_shape", shape_code, 0);

    // Hysteresis commit after a clean restart
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_no_done", window_done, 0);
    window(3, 0, 0, 10, 0, 0, 0, 0, 0);
    check("hyst1_cand", cand_code, 3);
    check("hyst1_shape", shape_code, 0);
    window(3, 0, 0, 10, 0, 0, 0, 0, 0);
    check("hyst2_pre", pre_shape, 0);
    check("hyst2_shape", shape_code, 3);
    window(2, 0, 10, 0, 1, 10, 0, 0, 0);
    check("mixed_cand", cand_code, 2);
    check("mixed_votes", win_votes, 2);
    check("mixed_shape", shape_code, 3);
    window(3, 0, 0, 10, 0, 0, 0, 0, 0);
    check("back_shape", shape_code, 3);

    // Margin and min-votes
    window(2, 10, 0, 0, 2, 0, 10, 0, 0);
    check("margin_cand", cand_code, 0);
    check("margin_votes", win_votes, 2);
    check("margin_shape", shape_code, 3);
    window(1, 10, 0, 0, 0, 0, 0, 0, 0);
    check("minv_cand", cand_code, 0);
    check("minv_votes", win_votes, 1);
    check("unk_pre", pre_shape, 3);
    check("unk_shape", shape_code, 0);

    // Vote on the timer==7 cycle belongs to that window
    window(1, 10, 0, 0, 0, 0, 0, 0, 7);
    check("edge_votes", win_votes, 1);
    window(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("edge_next_votes", win_votes, 0);

    // en=0 stall of 20 cycles with ignored votes
    cnt_edges = 0; stray = 0;
    valid_in = 1'b1; score0 = 0; score1 = 0; score2 = 10;
    tick(); tick(); cnt_edges += 2;
    en = 1'b0; score0 = 10; score2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); cnt_edges++;
      if (window_done) stray++;
    end
    en = 1'b1; score0 = 0; score2 = 10;
    tick(); cnt_edges++;
    valid_in = 1'b0;
    for (int i = 0; i < 12 && !window_done; i++) begin
      tick(); cnt_edges++;
    end
    check("stall_no_done", stray, 0);
    check("stall_latency", cnt_edges, 28);
    check("stall_cand", cand_code, 3);
    check("stall_votes", win_votes, 3);

    // clear on the window-end cycle
    for (int i = 0; i < 7; i++) begin
      valid_in = (i < 3); score0 = 0; score1 = 0; score2 = 10;
      tick();
    end
    clear = 1'b1; valid_in = 1'b1;
    tick();
    clear = 1'b0; valid_in = 1'b0;
    check("clr_end_done", window_done, 0);
    check("clr_end_shape", shape_code, 0);
    window(3, 0, 0, 10, 0, 0, 0, 0, 0);
    check("clr_fsm_cand", cand_code, 3);
    check("clr_fsm_shape", shape_code, 0);
    window(3, 0, 0, 10, 0, 0, 0, 0, 0);
    check("commit_I", shape_code, 3);

    // Async reset mid-window
    valid_in = 1'b1; score0 = 10; score1 = 0; score2 = 0;
    tick(); tick(); tick();
    valid_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_shape", shape_code, 0);
    check("arst_done", window_done, 0);
    check("arst_cand", cand_code, 0);
    check("arst_votes", win_votes, 0);
    #3 rst = 1'b0;
    cnt_edges = 0;
    for (int i = 0; i < 12 && !window_done; i++) begin
      tick(); cnt_edges++;
    end
    check("arst_latency", cnt_edges, 8);
    check("arst_fresh_votes", win_votes, 0);

    // Saturation on the narrow instance
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    score0 = 10; score1 = 0; score2 = 0;
    for (int i = 0; i < 10; i++) begin
      valid2 = (i < 9);
      tick();
    end
    valid2 = 1'b0;
    check("sat_done", window_done2, 1);
    check("sat_votes", win_votes2, 7);
    check("sat_cand", cand_code2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
